// File: rtl/xadc_pkg.sv
// Shared XADC definitions: DRP sequencer states, channel addresses and
// conversion-result geometry used by the DRP sampler slice.
package xadc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } drp_state_t;

    localparam logic [6:0]  VAUX15_ADDR = 7'h1F;
    localparam logic [6:0]  TEMP_ADDR   = 7'h00;
    localparam int unsigned ADC_BITS    = 12;
    localparam int unsigned DRP_WIDTH   = 16;

    // The conversion result is left-justified in the DRP status word.
    function automatic logic [ADC_BITS-1:0] adc_code(input logic [DRP_WIDTH-1:0] word);
        return word[DRP_WIDTH-1 -: ADC_BITS];
    endfunction

endpackage

// File: rtl/drp_timeout_counter.sv
// Loadable up-counter bounding how long the sampler waits for drdy.
module drp_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
    // tc fires on the increment that brings the count to TIMEOUT_CYCLES-1,
    // so the abort edge lands exactly TIMEOUT_CYCLES cycles after den.
    localparam logic [CW-1:0] TC_VALUE = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == TC_VALUE);

    // Next count: reload on request, otherwise advance while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xadc_drp_sampler.sv
// Issues one DRP read per XADC end-of-conversion, captures the result and
// reports it with a single-cycle valid strobe. Tracks overrun and timeout
// as sticky debug flags and counts successful captures.
module xadc_drp_sampler
    import xadc_pkg::*;
#(
    parameter logic [6:0]  CHANNEL_ADDR   = VAUX15_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eoc_in,
    input  logic                  drdy_in,
    input  logic [15:0]           do_in,
    output logic [6:0]            daddr_out,
    output logic                  den_out,
    output logic                  dwe_out,
    output logic [ADC_BITS-1:0]   sample,
    output logic [15:0]           sample_raw,
    output logic                  sample_valid,
    output logic                  overrun,
    output logic                  timeout,
    input  logic                  clear_flags,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    drp_state_t            state_q;
    logic                  den_q;
    logic                  valid_q;
    logic [ADC_BITS-1:0]   sample_q;
    logic [15:0]           raw_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  overrun_q;
    logic                  timeout_q;

    logic                  tc;
    logic                  overrun_set;
    logic                  timeout_set;

    drp_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (state_q == ST_REQ),
        .en_i   (state_q == ST_WAIT),
        .tc_o   (tc)
    );

    // Flag set events: EOC while busy, or no drdy before the deadline.
    always_comb begin
        overrun_set = eoc_in && (state_q != ST_IDLE);
        timeout_set = (state_q == ST_WAIT) && !drdy_in && tc;
    end

    // Read sequencer with registered DRP strobe and capture outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            den_q    <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            raw_q    <= '0;
            count_q  <= '0;
        end else begin
            den_q   <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (eoc_in) begin
                        state_q <= ST_REQ;
                        den_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (drdy_in) begin
                        raw_q    <= do_in;
                        sample_q <= adc_code(do_in);
                        valid_q  <= 1'b1;
                        count_q  <= count_q + CNT_WIDTH'(1);
                        state_q  <= ST_CAPTURE;
                    end else if (tc) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky debug flags; a set event wins over a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clear_flags) begin
                overrun_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (clear_flags) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign daddr_out    = CHANNEL_ADDR;
    assign dwe_out      = 1'b0;
    assign den_out      = den_q;
    assign sample_valid = valid_q;
    assign sample       = sample_q;
    assign sample_raw   = raw_q;
    assign sample_count = count_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Bench for the XADC DRP sampler: directed table, corner-case sequences and
// randomized traffic against a transaction-window reference model.
module tb_xadc_drp_sampler;

    localparam int unsigned T  = 16;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          eoc_in;
    logic          drdy_in;
    logic [15:0]   do_in;
    logic          clear_flags;
    logic [6:0]    daddr_out;
    logic          den_out;
    logic          dwe_out;
    logic [11:0]   sample;
    logic [15:0]   sample_raw;
    logic          sample_valid;
    logic          overrun;
    logic          timeout;
    logic [CW-1:0] sample_count;

    xadc_drp_sampler #(
        .CHANNEL_ADDR   (7'h1F),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .eoc_in       (eoc_in),
        .drdy_in      (drdy_in),
        .do_in        (do_in),
        .daddr_out    (daddr_out),
        .den_out      (den_out),
        .dwe_out      (dwe_out),
        .sample       (sample),
        .sample_raw   (sample_raw),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .timeout      (timeout),
        .clear_flags  (clear_flags),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int t = 0;

    // Reference model: a read owns the bus from the accepted EOC until
    // idle_at; drdy counts only within the window after the den cycle.
    int            idle_at;
    int            den_cyc;
    bit            pending;
    logic          m_den;
    logic          m_valid;
    logic [11:0]   m_sample;
    logic [15:0]   m_raw;
    logic [CW-1:0] m_count;
    logic          m_ovr;
    logic          m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, t, act, req);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        idle_at  = 0;
        den_cyc  = 0;
        pending  = 0;
        m_den    = 0;
        m_valid  = 0;
        m_sample = '0;
        m_raw    = '0;
        m_count  = '0;
        m_ovr    = 0;
        m_to     = 0;
    endtask

    task automatic model_step(input logic e, input logic d, input logic [15:0] w, input logic c);
        bit ovr_set;
        bit to_set;
        ovr_set = 0;
        to_set  = 0;
        m_den   = 0;
        m_valid = 0;
        if (t >= idle_at) begin
            if (e) begin
                pending = 1;
                den_cyc = t + 1;
                idle_at = den_cyc + int'(T);
                m_den   = 1;
            end
        end else begin
            if (e) ovr_set = 1;
            if (pending && t > den_cyc && t < den_cyc + int'(T)) begin
                if (d) begin
                    m_raw    = w;
                    m_sample = w[15:4];
                    m_count  = m_count + 1'b1;
                    m_valid  = 1;
                    idle_at  = t + 2;
                    pending  = 0;
                end else if (t == den_cyc + int'(T) - 1) begin
                    to_set  = 1;
                    pending = 0;
                end
            end
        end
        if (ovr_set) m_ovr = 1; else if (c) m_ovr = 0;
        if (to_set)  m_to  = 1; else if (c) m_to  = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".den"},     den_out,      m_den);
        chk({tag, ".valid"},   sample_valid, m_valid);
        chk({tag, ".sample"},  sample,       m_sample);
        chk({tag, ".raw"},     sample_raw,   m_raw);
        chk({tag, ".count"},   sample_count, m_count);
        chk({tag, ".overrun"}, overrun,      m_ovr);
        chk({tag, ".timeout"}, timeout,      m_to);
        chk({tag, ".daddr"},   daddr_out,    7'h1F);
        chk({tag, ".dwe"},     dwe_out,      1'b0);
    endtask

    task automatic step(input logic e, input logic d, input logic [15:0] w, input logic c, input string tag);
        eoc_in      = e;
        drdy_in     = d;
        do_in       = w;
        clear_flags = c;
        model_step(e, d, w, c);
        @(posedge clk);
        #1;
        compare_all(tag);
        t++;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        repeat (cycles) begin
            @(posedge clk);
            #1;
            compare_all("rst");
            t++;
        end
        reset = 1'b1;
    endtask

    task automatic read_once(input int lat, input logic [15:0] w);
        step(1, 0, 16'h0, 0, "rd");
        repeat (lat) step(0, 0, 16'h0, 0, "rd");
        step(0, 1, w, 0, "rd");
        step(0, 0, 16'h0, 0, "rd");
    endtask

    typedef struct {
        logic        eoc;
        logic        drdy;
        logic [15:0] dat;
        logic        clr;
        logic        e_den;
        logic        e_valid;
        logic [11:0] e_sample;
        logic [15:0] e_raw;
        logic [3:0]  e_count;
        logic [1:0]  e_flags;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic e, input logic d, input logic [15:0] w,
                                input logic ed, input logic ev, input logic [11:0] es,
                                input logic [15:0] er, input logic [3:0] ec);
        vec_t v;
        v.eoc = e; v.drdy = d; v.dat = w; v.clr = 1'b0;
        v.e_den = ed; v.e_valid = ev; v.e_sample = es; v.e_raw = er;
        v.e_count = ec; v.e_flags = 2'b00;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nvalid;
        int dens;

        // Basic read: den one cycle after EOC, drdy three cycles after den,
        // then a stray drdy in IDLE that must not disturb the capture.
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        vecs[3]  = mk(1, 0, 16'h0000, 1, 0, 12'h000, 16'h0000, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        vecs[7]  = mk(0, 1, 16'hABC0, 0, 1, 12'hABC, 16'hABC0, 1);
        vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 12'hABC, 16'hABC0, 1);
        vecs[9]  = mk(0, 1, 16'hFFFF, 0, 0, 12'hABC, 16'hABC0, 1);
        vecs[10] = mk(0, 0, 16'hFFFF, 0, 0, 12'hABC, 16'hABC0, 1);

        reset = 1'b0; eoc_in = 0; drdy_in = 0; do_in = '0; clear_flags = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("init");
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].eoc, vecs[i].drdy, vecs[i].dat, vecs[i].clr, "tbl");
            chk("tbl.den",    den_out,      vecs[i].e_den);
            chk("tbl.valid",  sample_valid, vecs[i].e_valid);
            chk("tbl.sample", sample,       vecs[i].e_sample);
            chk("tbl.raw",    sample_raw,   vecs[i].e_raw);
            chk("tbl.count",  sample_count, vecs[i].e_count);
            chk("tbl.flags",  {overrun, timeout}, vecs[i].e_flags);
        end

        // Timeout: no drdy, flag appears exactly T cycles after den.
        step(1, 0, 16'h0, 0, "to");
        chk("to.den", den_out, 1'b1);
        k = 0;
        nvalid = 0;
        while (timeout !== 1'b1 && k < 4 * int'(T)) begin
            step(0, 0, 16'h0, 0, "to");
            k++;
            if (sample_valid === 1'b1) nvalid++;
        end
        chk("to.latency", k, T);
        chk("to.no_valid", nvalid, 0);
        step(1, 0, 16'h0, 0, "to");
        chk("to.next_den", den_out, 1'b1);
        step(0, 0, 16'h0, 0, "to");
        step(0, 1, 16'h4560, 0, "to");
        chk("to.next_sample", sample, 12'h456);
        step(0, 0, 16'h0, 0, "to");
        chk("to.still_set", timeout, 1'b1);
        step(0, 0, 16'h0, 1, "to");
        chk("to.cleared", timeout, 1'b0);

        // Overrun: second EOC one cycle after den; single den pulse.
        dens = 0;
        step(1, 0, 16'h0, 0, "ov"); dens += int'(den_out);
        step(0, 0, 16'h0, 0, "ov"); dens += int'(den_out);
        step(1, 0, 16'h0, 0, "ov"); dens += int'(den_out);
        step(0, 0, 16'h0, 0, "ov"); dens += int'(den_out);
        step(0, 1, 16'h1230, 0, "ov"); dens += int'(den_out);
        step(0, 0, 16'h0, 0, "ov"); dens += int'(den_out);
        step(0, 0, 16'h0, 0, "ov"); dens += int'(den_out);
        chk("ov.flag", overrun, 1'b1);
        chk("ov.dens", dens, 1);
        chk("ov.sample", sample, 12'h123);
        step(0, 0, 16'h0, 1, "ov");
        chk("ov.cleared", overrun, 1'b0);

        // Mid-read reset: later drdy ignored, next read behaves normally.
        step(1, 0, 16'h0, 0, "mr");
        step(0, 0, 16'h0, 0, "mr");
        do_reset(2);
        step(0, 1, 16'h5550, 0, "mr");
        chk("mr.valid", sample_valid, 1'b0);
        step(0, 0, 16'h0, 0, "mr");
        chk("mr.sample", sample, 12'h000);
        chk("mr.count", sample_count, 4'd0);
        read_once(2, 16'h7770);
        chk("mr.next_sample", sample, 12'h777);
        chk("mr.next_count", sample_count, 4'd1);

        // Counter wrap: 17 reads on a 4-bit counter.
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            read_once(1 + (i % 5), 16'(i * 16'h0110));
        end
        chk("wrap.count", sample_count, 4'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                     16'($urandom), $urandom_range(0, 15) == 0, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xadc_drp_sampler.md
Name: xadc_drp_sampler

Overview:
- Sequences Dynamic Reconfiguration Port (DRP) reads from the XADC wizard core on each end-of-conversion (EOC) pulse.
- Captures the 12-bit conversion result and presents it downstream with a one-cycle valid strobe.
- Sits between the XADC instance and the averaging/scaling stage, replacing the direct eoc-to-den tie.
- Adds timeout recovery, overrun detection and a sample counter for debug display.

Parameters:
- CHANNEL_ADDR, 7'h1F, DRP status-register address read on each EOC (VAUX15).
- TIMEOUT_CYCLES, 64, maximum cycles to wait for drdy after den before aborting.
- CNT_WIDTH, 16, width of the sample counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- eoc_in  input  1  end-of-conversion pulse from XADC.
- drdy_in  input  1  DRP data-ready from XADC.
- do_in  input  16  DRP read data from XADC.
- daddr_out  output  7  DRP address.
- den_out  output  1  DRP enable, single-cycle pulse.
- dwe_out  output  1  DRP write enable, constant 0.
- sample  output  12  last captured conversion, do_in[15:4].
- sample_raw  output  16  last captured full DRP word.
- sample_valid  output  1  one-cycle strobe when sample/sample_raw update.
- overrun  output  1  sticky: EOC arrived while a read was in progress.
- timeout  output  1  sticky: drdy not seen within TIMEOUT_CYCLES.
- clear_flags  input  1  synchronous clear of overrun and timeout.
- sample_count  output  CNT_WIDTH  number of successful captures, wraps.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset state:
  - FSM enters IDLE.
  - den_out, sample_valid, overrun and timeout are 0.
  - sample, sample_raw and sample_count are 0.
  - daddr_out is CHANNEL_ADDR at all times.
  - dwe_out is 0 at all times.
- FSM states: IDLE, REQ, WAIT, CAPTURE.
- IDLE: on eoc_in=1, go to REQ.
- REQ: den_out=1 for exactly this one cycle; wait counter loads 0; go to WAIT.
- WAIT: counter increments each cycle.
  - drdy_in=1: register do_in into sample_raw, do_in[15:4] into sample; go to CAPTURE.
  - Else if the counter reaches TIMEOUT_CYCLES-1: set timeout; go to IDLE with no capture.
  - drdy takes priority over timeout in the same cycle.
- CAPTURE: sample_valid=1 for one cycle; sample_count increments (wraps at 2^CNT_WIDTH); go to IDLE.
- Latency: eoc in cycle N, drdy in cycle N+1+k (k is the XADC latency) -> sample_valid in cycle N+2+k, with data stable from the same cycle.
- sample and sample_raw hold their values between captures.
- drdy_in outside WAIT is ignored.
- eoc_in in REQ, WAIT or CAPTURE:
  - Set overrun.
  - The in-progress read completes normally.
  - The pending EOC is not queued.
- clear_flags:
  - Clears overrun and timeout next cycle.
  - If clear_flags and a set event coincide, the set wins.
- Reset asserted mid-read returns to IDLE immediately; a later stray drdy is ignored.
- den_out is never asserted in back-to-back cycles; at most one outstanding DRP transaction.

Decomposition:
- Shared package xadc_pkg holds:
  - the state enum type drp_state_t;
  - XADC address constants (VAUX15_ADDR=7'h1F, TEMP_ADDR=7'h00);
  - ADC_BITS=12.
- One sub-module, drp_timeout_counter: loadable up-counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Basic read: eoc at cycle 10, drdy 3 cycles after den with do_in=16'hABC0 -> den at cycle 11 only; sample=12'hABC, sample_raw=16'hABC0 with sample_valid in the cycle after drdy; sample_count=1.
- Timeout: eoc, drdy never asserted -> timeout=1 exactly TIMEOUT_CYCLES cycles after den; no sample_valid; FSM accepts the next eoc; clear_flags -> timeout=0.
- Overrun: second eoc 1 cycle after den, drdy later with 16'h1230 -> overrun=1; exactly one den pulse; sample=12'h123.
- Stray drdy in IDLE with do_in=16'hFFFF -> sample unchanged; no sample_valid.
- Mid-read reset: eoc then den, reset low for 2 cycles before drdy, release, then drdy -> all outputs 0; no capture; next eoc works normally.
- Counter wrap with CNT_WIDTH=4: 17 complete reads -> sample_count=1 after the 17th.
